// File: rtl/id_regfile_pkg.sv
// Shared types and helpers for the ID-stage multi-port register file.
// REG_N_DEF follows the ISA build: 16 registers for RV32E, 32 otherwise.
package id_regfile_pkg;

  localparam int REG_ADDR_W = 5;

`ifdef CONFIG_ISA_RV32E
  localparam int REG_N_DEF = 16;
`else
  localparam int REG_N_DEF = 32;
`endif

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // A register is architecturally writable/readable when it is not x0 and exists.
  function automatic logic reg_legal(input reg_addr_t addr, input int reg_n);
    return (addr != '0) && (32'(addr) < reg_n);
  endfunction

endpackage

// File: rtl/id_regfile_if.sv
// Issue-side bundle of the ID register file: write-back ports, destination
// allocation and operand reads.
interface id_regfile_if #(
  parameter int XLEN     = 32,
  parameter int RD_PORTS = 2,
  parameter int WR_PORTS = 1
);
  import id_regfile_pkg::*;

  logic [WR_PORTS-1:0]            rd_wr_en_i;
  logic [REG_ADDR_W*WR_PORTS-1:0] rd_wr_addr_i;
  logic [XLEN*WR_PORTS-1:0]       rd_wr_data_i;
  logic                           rd_alloc_en_i;
  reg_addr_t                      rd_alloc_addr_i;
  logic [REG_ADDR_W*RD_PORTS-1:0] rs_rd_addr_i;
  logic [XLEN*RD_PORTS-1:0]       rs_rd_data_o;
  logic [RD_PORTS-1:0]            rs_busy_o;
  logic [RD_PORTS-1:0]            rs_ill_o;

  modport master (
    output rd_wr_en_i, rd_wr_addr_i, rd_wr_data_i,
    output rd_alloc_en_i, rd_alloc_addr_i, rs_rd_addr_i,
    input  rs_rd_data_o, rs_busy_o, rs_ill_o
  );

  modport slave (
    input  rd_wr_en_i, rd_wr_addr_i, rd_wr_data_i,
    input  rd_alloc_en_i, rd_alloc_addr_i, rs_rd_addr_i,
    output rs_rd_data_o, rs_busy_o, rs_ill_o
  );

endinterface

// File: rtl/id_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register, set on
// destination allocation and cleared when the producing write retires.
module id_scoreboard
  import id_regfile_pkg::*;
#(
  parameter int REG_N    = 32,
  parameter int WR_PORTS = 1
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic [WR_PORTS-1:0]            wr_en,
  input  logic [REG_ADDR_W*WR_PORTS-1:0] wr_addr,
  input  logic                           alloc_en,
  input  reg_addr_t                      alloc_addr,
  output logic [REG_N-1:0]               busy
);

  logic [REG_N-1:0] busy_q;
  logic [REG_N-1:0] busy_d;

  // Alloc is applied after retirement so a new producer supersedes the old one.
  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < REG_N; r++) begin
      for (int p = 0; p < WR_PORTS; p++) begin
        if (wr_en[p] && (wr_addr[REG_ADDR_W*p +: REG_ADDR_W] == REG_ADDR_W'(r))) begin
          busy_d[r] = 1'b0;
        end
      end
      if (alloc_en && (alloc_addr == REG_ADDR_W'(r))) begin
        busy_d[r] = 1'b1;
      end
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/id_regfile_mp.sv
// Multi-port ID-stage integer register file with optional write-to-read
// bypass and a pending-write scoreboard for RAW hazard detection.
module id_regfile_mp
  import id_regfile_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int REG_N    = REG_N_DEF,
  parameter int RD_PORTS = 2,
  parameter int WR_PORTS = 1,
  parameter int BYPASS   = 1
) (
  input logic        clk_i,
  input logic        rst_n_i,
  id_regfile_if.slave bus
);

  logic [XLEN-1:0]  regs_q [REG_N];
  logic [XLEN-1:0]  regs_d [REG_N];
  logic [REG_N-1:0] busy_vec;
  reg_addr_t        wr_addr [WR_PORTS];
  logic [XLEN-1:0]  wr_data [WR_PORTS];

  for (genvar p = 0; p < WR_PORTS; p++) begin : g_wr
    assign wr_addr[p] = bus.rd_wr_addr_i[REG_ADDR_W*p +: REG_ADDR_W];
    assign wr_data[p] = bus.rd_wr_data_i[XLEN*p +: XLEN];
  end

  // Ascending port order: the highest-indexed port targeting a register wins.
  // x0 and out-of-range addresses never match, so those writes vanish.
  always_comb begin
    regs_d = regs_q;
    for (int r = 1; r < REG_N; r++) begin
      for (int p = 0; p < WR_PORTS; p++) begin
        if (bus.rd_wr_en_i[p] && (wr_addr[p] == REG_ADDR_W'(r))) begin
          regs_d[r] = wr_data[p];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  id_scoreboard #(
    .REG_N    (REG_N),
    .WR_PORTS (WR_PORTS)
  ) u_scoreboard (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .wr_en      (bus.rd_wr_en_i),
    .wr_addr    (bus.rd_wr_addr_i),
    .alloc_en   (bus.rd_alloc_en_i),
    .alloc_addr (bus.rd_alloc_addr_i),
    .busy       (busy_vec)
  );

  for (genvar i = 0; i < RD_PORTS; i++) begin : g_rd
    reg_addr_t       raddr;
    logic [XLEN-1:0] data;
    logic            busy;

    assign raddr = bus.rs_rd_addr_i[REG_ADDR_W*i +: REG_ADDR_W];

    always_comb begin
      data = '0;
      busy = 1'b0;
      if (reg_legal(raddr, REG_N)) begin
        for (int r = 0; r < REG_N; r++) begin
          if (raddr == REG_ADDR_W'(r)) begin
            data = regs_q[r];
            busy = busy_vec[r];
          end
        end
        // A same-cycle write is the youngest value and has already retired.
        if (BYPASS != 0) begin
          for (int p = 0; p < WR_PORTS; p++) begin
            if (bus.rd_wr_en_i[p] && (wr_addr[p] == raddr)) begin
              data = wr_data[p];
              busy = 1'b0;
            end
          end
        end
      end
    end

    assign bus.rs_rd_data_o[XLEN*i +: XLEN] = data;
    assign bus.rs_busy_o[i]                 = busy;
    assign bus.rs_ill_o[i]                  = (32'(raddr) >= REG_N);
  end

endmodule

// File: tb/tb_id_regfile_mp.sv
// Bench for id_regfile_mp: a 32-entry, two-write-port bypassing file and a
// 16-entry, single-write-port registered file share one stimulus stream.
module tb_id_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  wr_en;
  logic [4:0]  wr_addr [2];
  logic [31:0] wr_data [2];
  logic        alloc_en;
  logic [4:0]  alloc_addr;
  logic [4:0]  rd_addr [2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_regfile_if #(.XLEN(32), .RD_PORTS(2), .WR_PORTS(2)) bus_a ();
  id_regfile_if #(.XLEN(32), .RD_PORTS(2), .WR_PORTS(1)) bus_b ();

  assign bus_a.rd_wr_en_i      = wr_en;
  assign bus_a.rd_wr_addr_i    = {wr_addr[1], wr_addr[0]};
  assign bus_a.rd_wr_data_i    = {wr_data[1], wr_data[0]};
  assign bus_a.rd_alloc_en_i   = alloc_en;
  assign bus_a.rd_alloc_addr_i = alloc_addr;
  assign bus_a.rs_rd_addr_i    = {rd_addr[1], rd_addr[0]};

  assign bus_b.rd_wr_en_i      = wr_en[0];
  assign bus_b.rd_wr_addr_i    = wr_addr[0];
  assign bus_b.rd_wr_data_i    = wr_data[0];
  assign bus_b.rd_alloc_en_i   = alloc_en;
  assign bus_b.rd_alloc_addr_i = alloc_addr;
  assign bus_b.rs_rd_addr_i    = {rd_addr[1], rd_addr[0]};

  id_regfile_mp #(.XLEN(32), .REG_N(32), .RD_PORTS(2), .WR_PORTS(2), .BYPASS(1)) dut_a (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus_a)
  );

  id_regfile_mp #(.XLEN(32), .REG_N(16), .RD_PORTS(2), .WR_PORTS(1), .BYPASS(0)) dut_b (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus_b)
  );

  // Reference model: index 0 is the bypassing 32-entry file, 1 the 16-entry one.
  localparam int N_OF  [2] = '{32, 16};
  localparam int WP_OF [2] = '{2, 1};
  localparam int BYP_OF[2] = '{1, 0};

  logic [31:0] m_regs [2][32];
  logic        m_busy [2][32];
  logic        m_valid = 1'b0;

  function automatic bit m_legal(input int d, input logic [4:0] a);
    return (a != 5'd0) && (int'(a) < N_OF[d]);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++)
        for (int r = 0; r < 32; r++) begin
          m_regs[d][r] <= 32'd0;
          m_busy[d][r] <= 1'b0;
        end
      m_valid <= 1'b1;
    end else begin
      for (int d = 0; d < 2; d++) begin
        for (int p = 0; p < WP_OF[d]; p++)
          if (wr_en[p] && m_legal(d, wr_addr[p])) begin
            m_regs[d][wr_addr[p]] <= wr_data[p];
            m_busy[d][wr_addr[p]] <= 1'b0;
          end
        if (alloc_en && m_legal(d, alloc_addr))
          m_busy[d][alloc_addr] <= 1'b1;
      end
    end
  end

  function automatic void m_read(input int d, input logic [4:0] a,
                                 output logic [31:0] data, output logic busy,
                                 output logic ill);
    ill  = (int'(a) >= N_OF[d]);
    data = 32'd0;
    busy = 1'b0;
    if (m_legal(d, a)) begin
      data = m_regs[d][a];
      busy = m_busy[d][a];
      if (BYP_OF[d] != 0)
        for (int p = 0; p < WP_OF[d]; p++)
          if (wr_en[p] && wr_addr[p] == a) begin
            data = wr_data[p];
            busy = 1'b0;
          end
    end
  endfunction

  function automatic logic [31:0] act_data(input int d, input int i);
    return (d == 0) ? bus_a.rs_rd_data_o[32*i +: 32] : bus_b.rs_rd_data_o[32*i +: 32];
  endfunction

  function automatic logic act_busy(input int d, input int i);
    return (d == 0) ? bus_a.rs_busy_o[i] : bus_b.rs_busy_o[i];
  endfunction

  function automatic logic act_ill(input int d, input int i);
    return (d == 0) ? bus_a.rs_ill_o[i] : bus_b.rs_ill_o[i];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Every negedge once the model has seen a reset: all ports of both files.
  always @(negedge clk) begin
    if (m_valid) begin
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < 2; i++) begin
          logic [31:0] e_data;
          logic        e_busy;
          logic        e_ill;
          m_read(d, rd_addr[i], e_data, e_busy, e_ill);
          check($sformatf("model d%0d p%0d data a=%0d", d, i, rd_addr[i]), act_data(d, i), e_data);
          check($sformatf("model d%0d p%0d busy a=%0d", d, i, rd_addr[i]), 32'(act_busy(d, i)), 32'(e_busy));
          check($sformatf("model d%0d p%0d ill a=%0d", d, i, rd_addr[i]), 32'(act_ill(d, i)), 32'(e_ill));
        end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en    = 2'b00;
    alloc_en = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    wr_en      = 2'b01;
    wr_addr[0] = 5'd5;  wr_data[0] = 32'hDEAD;
    wr_addr[1] = 5'd0;  wr_data[1] = 32'd0;
    alloc_en   = 1'b0;  alloc_addr = 5'd0;
    rd_addr[0] = 5'd0;  rd_addr[1] = 5'd0;
    tick();

    // Reset dominated the concurrent write to x5.
    rst_n = 1'b1;
    idle_inputs();
    rd_addr[0] = 5'd5;
    #2;
    check("rst_write_x5_a", act_data(0, 0), 32'd0);
    check("rst_write_x5_b", act_data(1, 0), 32'd0);

    for (int a = 1; a < 32; a++) begin
      rd_addr[0] = 5'(a);
      rd_addr[1] = 5'(a);
      #2;
      check($sformatf("rst_data x%0d", a), act_data(0, 1), 32'd0);
      check($sformatf("rst_busy x%0d", a), 32'(act_busy(0, 0)), 32'd0);
      check($sformatf("rst_ill x%0d", a),  32'(act_ill(0, 1)), 32'd0);
      tick();
    end

    wr_en = 2'b01; wr_addr[0] = 5'd0; wr_data[0] = 32'hFFFF_FFFF;
    tick();
    idle_inputs();
    rd_addr[0] = 5'd0;
    #2;
    check("x0_a", act_data(0, 0), 32'd0);
    check("x0_b", act_data(1, 0), 32'd0);
    tick();

    wr_en = 2'b01; wr_addr[0] = 5'd20; wr_data[0] = 32'h1234;
    tick();
    idle_inputs();
    rd_addr[0] = 5'd20;
    #2;
    check("x20_data_b", act_data(1, 0), 32'd0);
    check("x20_ill_b", 32'(act_ill(1, 0)), 32'd1);
    check("x20_data_a", act_data(0, 0), 32'h1234);
    check("x20_ill_a", 32'(act_ill(0, 0)), 32'd0);
    tick();

    wr_en = 2'b01; wr_addr[0] = 5'd7; wr_data[0] = 32'hA5A5_A5A5;
    rd_addr[0] = 5'd7;
    #2;
    check("bypass_data_a", act_data(0, 0), 32'hA5A5_A5A5);
    check("bypass_busy_a", 32'(act_busy(0, 0)), 32'd0);
    check("nobypass_old_b", act_data(1, 0), 32'd0);
    tick();
    idle_inputs();
    #2;
    check("nobypass_new_b", act_data(1, 0), 32'hA5A5_A5A5);
    tick();

    wr_en = 2'b11;
    wr_addr[0] = 5'd3; wr_data[0] = 32'h11;
    wr_addr[1] = 5'd3; wr_data[1] = 32'h22;
    rd_addr[0] = 5'd3;
    #2;
    check("dual_bypass_a", act_data(0, 0), 32'h22);
    tick();
    idle_inputs();
    #2;
    check("dual_stored_a", act_data(0, 0), 32'h22);
    check("port0_stored_b", act_data(1, 0), 32'h11);
    tick();

    alloc_en = 1'b1; alloc_addr = 5'd9;
    tick();
    idle_inputs();
    rd_addr[0] = 5'd9;
    #2;
    check("alloc9_busy_a", 32'(act_busy(0, 0)), 32'd1);
    check("alloc9_busy_b", 32'(act_busy(1, 0)), 32'd1);
    tick();
    wr_en = 2'b01; wr_addr[0] = 5'd9; wr_data[0] = 32'h55;
    tick();
    idle_inputs();
    #2;
    check("retire9_busy_a", 32'(act_busy(0, 0)), 32'd0);
    check("retire9_data_a", act_data(0, 0), 32'h55);
    check("retire9_busy_b", 32'(act_busy(1, 0)), 32'd0);
    tick();
    wr_en = 2'b01; wr_addr[0] = 5'd9; wr_data[0] = 32'h66;
    alloc_en = 1'b1; alloc_addr = 5'd9;
    tick();
    idle_inputs();
    #2;
    check("realloc9_busy_a", 32'(act_busy(0, 0)), 32'd1);
    check("realloc9_data_a", act_data(0, 0), 32'h66);
    check("realloc9_busy_b", 32'(act_busy(1, 0)), 32'd1);
    check("realloc9_data_b", act_data(1, 0), 32'h66);
    tick();

    alloc_en = 1'b1; alloc_addr = 5'd4;
    tick();
    idle_inputs();
    rd_addr[1] = 5'd4;
    #2;
    check("alloc4_busy_a", 32'(act_busy(0, 1)), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #2;
    check("rst4_busy_a", 32'(act_busy(0, 1)), 32'd0);
    check("rst4_busy_b", 32'(act_busy(1, 1)), 32'd0);
    tick();

    for (int n = 0; n < 10000; n++) begin
      rst_n = ($urandom_range(0, 255) != 0);
      wr_en = 2'($urandom_range(0, 3));
      for (int p = 0; p < 2; p++) begin
        wr_addr[p] = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
        wr_data[p] = $urandom;
      end
      alloc_en   = ($urandom_range(0, 2) == 0);
      alloc_addr = 5'($urandom_range(0, 31));
      for (int i = 0; i < 2; i++)
        rd_addr[i] = ($urandom_range(0, 1) != 0) ? wr_addr[$urandom_range(0, 1)] : 5'($urandom_range(0, 31));
      tick();
    end

    rst_n = 1'b1;
    idle_inputs();
    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
